aim_instruction_encoder: RTL and testbench

- Assembles 32-bit AIM instructions from separate fields and issues them through a small FIFO to the instruction stream consumed by the AIM decoder.
- Sits between the command front-end (compiler/driver port) and the instruction fetch path, so it is the producer end of the AIM instruction format.
- Rejects requests whose type field is not a legal class; optional statistics counters.

---
 rtl/aim_pkg.sv | 39 +++
 rtl/aim_instruction_encoder_if.sv | 36 +++
 rtl/aim_sync_fifo.sv | 73 +++++++
 rtl/aim_instruction_encoder.sv | 119 +++++++++++
 tb/tb_aim_instruction_encoder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aim_pkg.sv
// Shared AIM instruction format definitions used by the encoder and the decoder.
// Holds the instruction class codes, the field bit positions, the packed
// instruction layout and the instruction-class legality check.
package aim_pkg;

    // Instruction classes; every other 4-bit value is illegal
    localparam logic [3:0] AIM_TYPE_AI  = 4'b0001;
    localparam logic [3:0] AIM_TYPE_GFX = 4'b0010;

    // Field bit positions within the 32-bit instruction word
    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 28;
    localparam int SUB_MSB  = 27;
    localparam int SUB_LSB  = 24;
    localparam int OP_MSB   = 23;
    localparam int OP_LSB   = 18;
    localparam int SRC_MSB  = 17;
    localparam int SRC_LSB  = 10;
    localparam int DST_MSB  = 9;
    localparam int DST_LSB  = 2;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Packed instruction view; operand holds either {dst,2'b00} or
    // {dst[7:6],imm} depending on how the word was built
    typedef struct packed {
        logic [3:0] itype;
        logic [3:0] subtype;
        logic [5:0] opcode;
        logic [7:0] src;
        logic [9:0] operand;
    } aim_instr_t;

    // True when the instruction class is one the decoder understands
    function automatic logic aim_is_legal(input logic [3:0] t);
        return (t == AIM_TYPE_AI) || (t == AIM_TYPE_GFX);
    endfunction

endpackage

// File: rtl/aim_instruction_encoder_if.sv
// Request/response bundle between the command front-end, the encoder and the
// instruction fetch path.
// Both sides use valid/ready: a beat transfers on the rising edge where valid
// and ready are both high; ready never depends on valid, and a producer keeps
// its payload stable while valid is high and ready is low.
interface aim_instruction_encoder_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_type;
    logic [3:0]  req_subtype;
    logic [5:0]  req_opcode;
    logic [7:0]  req_src;
    logic [7:0]  req_dst;
    logic [7:0]  req_imm;
    logic        req_use_imm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;

    // Environment side: drives requests, consumes instructions
    modport master (
        output req_valid, req_type, req_subtype, req_opcode,
               req_src, req_dst, req_imm, req_use_imm, out_ready,
        input  req_ready, out_valid, out_instr
    );

    // Encoder side
    modport slave (
        input  req_valid, req_type, req_subtype, req_opcode,
               req_src, req_dst, req_imm, req_use_imm, out_ready,
        output req_ready, out_valid, out_instr
    );

endinterface

// File: rtl/aim_sync_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits.
// Full/empty are derived from the occupancy count; pointers wrap naturally.
// flush clears the FIFO at the next edge and overrides any push/pop that cycle.
// Pushes while full and pops while empty are ignored internally.
module aim_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [AW:0]  occupancy_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;
    assign dout_o      = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Next pointers and count; flush wins over any transfer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/aim_instruction_encoder.sv
// AIM instruction encoder: packs request fields into a 32-bit instruction,
// drops requests with an illegal class (pulsing err_illegal) and queues legal
// instructions in a small FIFO towards the instruction fetch path.
// Optional statistics counters are enabled with the AIM_ENC_STATS_EN macro.
// DEPTH must be a power of two and at least 2.
module aim_instruction_encoder
    import aim_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef AIM_ENC_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    aim_instruction_encoder_if.slave bus,
    input  logic                     flush,
    output logic                     err_illegal,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef AIM_ENC_STATS_EN
    , output logic [CNT_W-1:0]       stat_issued
    , output logic [CNT_W-1:0]       stat_rejected
`endif
);

    // Build the instruction word; with an immediate, dst[5:0] is deliberately
    // overwritten by imm and only dst[7:6] survives in bits [9:8]
    function automatic logic [31:0] aim_pack(
        input logic [3:0] t,
        input logic [3:0] s,
        input logic [5:0] op,
        input logic [7:0] src,
        input logic [7:0] dst,
        input logic [7:0] imm,
        input logic       use_imm
    );
        logic [31:0] w;
        w = '0;
        w[TYPE_MSB:TYPE_LSB] = t;
        w[SUB_MSB:SUB_LSB]   = s;
        w[OP_MSB:OP_LSB]     = op;
        w[SRC_MSB:SRC_LSB]   = src;
        if (use_imm) begin
            w[DST_MSB:DST_MSB-1] = dst[7:6];
            w[IMM_MSB:IMM_LSB]   = imm;
        end else begin
            w[DST_MSB:DST_LSB] = dst;
        end
        return w;
    endfunction

    aim_instr_t enc_word;
    logic       fifo_full, fifo_empty;
    logic       req_xfer, req_legal, push, pop;
    logic       err_q, err_d;

    assign enc_word = aim_instr_t'(aim_pack(bus.req_type, bus.req_subtype, bus.req_opcode,
                                            bus.req_src, bus.req_dst, bus.req_imm,
                                            bus.req_use_imm));

    assign req_legal     = aim_is_legal(bus.req_type);
    assign bus.req_ready = !fifo_full && !flush;
    assign req_xfer      = bus.req_valid && bus.req_ready;
    assign push          = req_xfer && req_legal;
    assign bus.out_valid = !fifo_empty;
    assign pop           = !fifo_empty && bus.out_ready && !flush;
    assign err_d         = req_xfer && !req_legal;
    assign err_illegal   = err_q;

    aim_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .din_i       (enc_word),
        .dout_o      (bus.out_instr),
        .occupancy_o (occupancy),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // One-cycle error pulse following each dropped illegal request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

`ifdef AIM_ENC_STATS_EN
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] rejected_q, rejected_d;

    // Saturating counters; flush does not clear them
    always_comb begin
        issued_d   = issued_q;
        rejected_d = rejected_q;
        if (pop && (issued_q != '1))     issued_d   = issued_q + CNT_W'(1);
        if (err_d && (rejected_q != '1)) rejected_d = rejected_q + CNT_W'(1);
    end

    // Statistics registers, cleared by reset only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q   <= '0;
            rejected_q <= '0;
        end else begin
            issued_q   <= issued_d;
            rejected_q <= rejected_d;
        end
    end

    assign stat_issued   = issued_q;
    assign stat_rejected = rejected_q;
`endif

endmodule

// File: tb/tb_aim_instruction_encoder.sv
// Bench for aim_instruction_encoder: directed scenarios followed by random
// traffic, all checked against a queue-based model of the encoder.
module tb_aim_instruction_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          err_illegal;
  logic [AW:0]   occupancy;
`ifdef AIM_ENC_STATS_EN
  logic [CNT_W-1:0] stat_issued, stat_rejected;
`endif

  always #5 clk = ~clk;

  aim_instruction_encoder_if bus();

  aim_instruction_encoder #(.DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .err_illegal (err_illegal),
    .occupancy   (occupancy)
`ifdef AIM_ENC_STATS_EN
    , .stat_issued   (stat_issued)
    , .stat_rejected (stat_rejected)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic        err_exp = 1'b0;
  int          issued_m = 0;
  int          rejected_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word from the field rules, using plain arithmetic
  function automatic logic [31:0] model_word(input int t, input int s, input int op,
                                             input int src, input int dst, input int imm,
                                             input int use_imm);
    int unsigned low;
    if (use_imm != 0) low = (unsigned'(dst) / 64) * 256 + unsigned'(imm);
    else              low = unsigned'(dst) * 4;
    return 32'(unsigned'(t) * (1 << 28) + unsigned'(s) * (1 << 24) +
               unsigned'(op) * (1 << 18) + unsigned'(src) * (1 << 10) + low);
  endfunction

  // ---------------- compare process (model) ----------------
  always @(negedge clk) begin
    bit legal_m, acc_m, pop_m;
    if (!rst_n) begin
      exp_q.delete();
      err_exp    = 1'b0;
      issued_m   = 0;
      rejected_m = 0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_err", 32'(err_illegal), 32'd0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_instr", bus.out_instr, exp_q[0]);
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("req_ready", 32'(bus.req_ready), 32'((exp_q.size() < DEPTH) && !flush));
      chk("err_illegal", 32'(err_illegal), 32'(err_exp));
`ifdef AIM_ENC_STATS_EN
      chk("stat_issued", 32'(stat_issued), 32'(issued_m));
      chk("stat_rejected", 32'(stat_rejected), 32'(rejected_m));
`endif
      legal_m = (bus.req_type == 4'd1) || (bus.req_type == 4'd2);
      acc_m   = bus.req_valid && (exp_q.size() < DEPTH) && !flush;
      pop_m   = (exp_q.size() != 0) && bus.out_ready && !flush;
      err_exp = acc_m && !legal_m;
      if (acc_m && !legal_m && rejected_m < (1 << CNT_W) - 1) rejected_m++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop_m) begin
          void'(exp_q.pop_front());
          if (issued_m < (1 << CNT_W) - 1) issued_m++;
        end
        if (acc_m && legal_m)
          exp_q.push_back(model_word(int'(bus.req_type), int'(bus.req_subtype),
                                     int'(bus.req_opcode), int'(bus.req_src),
                                     int'(bus.req_dst), int'(bus.req_imm),
                                     int'(bus.req_use_imm)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_type    = 4'd0;
    bus.req_subtype = 4'd0;
    bus.req_opcode  = 6'd0;
    bus.req_src     = 8'd0;
    bus.req_dst     = 8'd0;
    bus.req_imm     = 8'd0;
    bus.req_use_imm = 1'b0;
    bus.out_ready   = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic set_req(input int t, input int s, input int op, input int src,
                         input int dst, input int imm, input int use_imm);
    bus.req_valid   = 1'b1;
    bus.req_type    = 4'(t);
    bus.req_subtype = 4'(s);
    bus.req_opcode  = 6'(op);
    bus.req_src     = 8'(src);
    bus.req_dst     = 8'(dst);
    bus.req_imm     = 8'(imm);
    bus.req_use_imm = 1'(use_imm);
  endtask

  task automatic set_rand_legal();
    set_req($urandom_range(1, 2), $urandom_range(0, 15), $urandom_range(0, 63),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1));
  endtask

  // Wait (bounded) for req_ready, then let the request transfer on one edge
  task automatic push_held();
    int budget = 0;
    while (!bus.req_ready && budget < 50) begin
      cyc();
      budget++;
    end
    if (budget >= 50) begin
      n_vec++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 50 cycles");
    end
    cyc();
    bus.req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] first_word;
    idle_inputs();
    repeat (3) cyc();
    chk("lit_reset_occ", 32'(occupancy), 32'd0);
    rst_n = 1'b1;
    cyc();

    // AI request, no immediate
    set_req(1, 3, 'h2A, 'h11, 'h22, 0, 0);
    push_held();
    chk("lit_ai_valid", 32'(bus.out_valid), 32'd1);
    chk("lit_ai_word", bus.out_instr, 32'h13A8_4488);
    chk("lit_model_ai", model_word(1, 3, 'h2A, 'h11, 'h22, 0, 0), 32'h13A8_4488);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("lit_ai_drained", 32'(occupancy), 32'd0);

    // GFX request with immediate
    set_req(2, 1, 1, 0, 'hC0, 'h5A, 1);
    push_held();
    chk("lit_gfx_word", bus.out_instr, 32'h2104_035A);
    chk("lit_model_gfx", model_word(2, 1, 1, 0, 'hC0, 'h5A, 1), 32'h2104_035A);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // Illegal class: consumed, not queued, one-cycle error pulse
    set_req(7, 0, 0, 0, 0, 0, 0);
    chk("lit_illegal_ready", 32'(bus.req_ready), 32'd1);
    cyc();
    bus.req_valid = 1'b0;
    chk("lit_illegal_err", 32'(err_illegal), 32'd1);
    chk("lit_illegal_occ", 32'(occupancy), 32'd0);
    chk("lit_illegal_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("lit_illegal_err_end", 32'(err_illegal), 32'd0);

    // Backpressure: four accepted, fifth held off, head stable
    set_req(1, 5, 9, 'h33, 'h44, 0, 0);
    first_word = model_word(1, 5, 9, 'h33, 'h44, 0, 0);
    push_held();
    for (int k = 0; k < 3; k++) begin
      set_rand_legal();
      push_held();
    end
    set_rand_legal();
    for (int k = 0; k < 3; k++) begin
      chk("lit_bp_ready", 32'(bus.req_ready), 32'd0);
      chk("lit_bp_occ", 32'(occupancy), 32'(DEPTH));
      chk("lit_bp_head", bus.out_instr, first_word);
      cyc();
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH) cyc();
    chk("lit_bp_drained", 32'(occupancy), 32'd0);
    bus.out_ready = 1'b0;
    set_rand_legal();
    push_held();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // Simultaneous push/pop at occupancy 2, long enough to wrap the pointers
    set_rand_legal(); push_held();
    set_rand_legal(); push_held();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_rand_legal();
      cyc();
      chk("lit_pp_occ", 32'(occupancy), 32'd2);
    end
    bus.req_valid = 1'b0;
    repeat (3) cyc();
    bus.out_ready = 1'b0;

    // Flush with three entries while a request is offered
    for (int k = 0; k < 3; k++) begin
      set_rand_legal();
      push_held();
    end
    set_rand_legal();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("lit_flush_occ", 32'(occupancy), 32'd0);
    chk("lit_flush_valid", 32'(bus.out_valid), 32'd0);
    cyc();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      set_req((sel < 4) ? 1 : (sel < 8) ? 2 : $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 49) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    // Reset mid-stream: outputs fall without waiting for a clock edge
    set_rand_legal(); push_held();
    set_rand_legal(); push_held();
    rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", 32'(bus.out_valid), 32'd0);
    chk("lit_arst_occ", 32'(occupancy), 32'd0);
    chk("lit_arst_instr", bus.out_instr, 32'h0);
    cyc();
    rst_n = 1'b1;
    set_rand_legal();
    push_held();
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    idle_inputs();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Overall time limit
  initial begin
    #2000000;
    n_vec++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
